// File: rtl/regfile_8x16_pkg.sv
// regfile_8x16_pkg: shared register-file constants and register-address type
package regfile_8x16_pkg;
    localparam int RF_DATA_W = 16;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/mux8to1_16.sv
// mux8to1_16: 16-bit 8:1 mux, select bits s0..s2 LSB first
module mux8to1_16
    import regfile_8x16_pkg::*;
(
    input  logic [RF_DATA_W-1:0] d0,
    input  logic [RF_DATA_W-1:0] d1,
    input  logic [RF_DATA_W-1:0] d2,
    input  logic [RF_DATA_W-1:0] d3,
    input  logic [RF_DATA_W-1:0] d4,
    input  logic [RF_DATA_W-1:0] d5,
    input  logic [RF_DATA_W-1:0] d6,
    input  logic [RF_DATA_W-1:0] d7,
    input  logic                 s0,
    input  logic                 s1,
    input  logic                 s2,
    output logic [RF_DATA_W-1:0] y
);
    assign y = s2 ? (s1 ? (s0 ? d7 : d6) : (s0 ? d5 : d4))
                  : (s1 ? (s0 ? d3 : d2) : (s0 ? d1 : d0));
endmodule

// File: rtl/reg16_en.sv
// reg16_en: 16-bit register with enable and asynchronous active-high reset
module reg16_en
    import regfile_8x16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [RF_DATA_W-1:0] d,
    output logic [RF_DATA_W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/regfile_8x16.sv
// regfile_8x16: 8x16 register file, one write port, two registered read ports with write-first bypass
module regfile_8x16
    import regfile_8x16_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int DEPTH   = RF_DEPTH,
    parameter int R0_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [RF_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 rd_en,
    input  logic [RF_ADDR_W-1:0] ra_addr,
    input  logic [RF_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]    ra_data,
    output logic [DATA_W-1:0]    rb_data,
    output logic                 rd_valid
);
    logic [DEPTH-1:0]  wsel;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DATA_W-1:0] ma, mb, a_d, b_d;
    logic              zero_a, zero_b;

    assign wsel = we ? ((DEPTH'(1) << waddr) & {{(DEPTH-1){1'b1}}, R0_ZERO == 0}) : '0;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_reg
            reg16_en u_reg (.clk(clk), .rst(rst), .en(wsel[i]), .d(wdata), .q(rf[i]));
        end
    endgenerate

    mux8to1_16 u_mux_a (
        .d0(rf[0]), .d1(rf[1]), .d2(rf[2]), .d3(rf[3]),
        .d4(rf[4]), .d5(rf[5]), .d6(rf[6]), .d7(rf[7]),
        .s0(ra_addr[0]), .s1(ra_addr[1]), .s2(ra_addr[2]), .y(ma)
    );
    mux8to1_16 u_mux_b (
        .d0(rf[0]), .d1(rf[1]), .d2(rf[2]), .d3(rf[3]),
        .d4(rf[4]), .d5(rf[5]), .d6(rf[6]), .d7(rf[7]),
        .s0(rb_addr[0]), .s1(rb_addr[1]), .s2(rb_addr[2]), .y(mb)
    );

    // a hardwired R0 wins over the bypass so a dropped write never leaks out
    assign zero_a = (R0_ZERO != 0) && (ra_addr == '0);
    assign zero_b = (R0_ZERO != 0) && (rb_addr == '0);
    assign a_d = zero_a ? '0 : (we && ra_addr == waddr) ? wdata : ma;
    assign b_d = zero_b ? '0 : (we && rb_addr == waddr) ? wdata : mb;

    reg16_en u_out_a (.clk(clk), .rst(rst), .en(rd_en), .d(a_d), .q(ra_data));
    reg16_en u_out_b (.clk(clk), .rst(rst), .en(rd_en), .d(b_d), .q(rb_data));

    always_ff @(posedge clk or posedge rst)
        if (rst) rd_valid <= 1'b0;
        else rd_valid <= rd_en;
endmodule

// File: tb/tb_regfile_8x16.sv
// tb_regfile_8x16: directed self-checking bench, default instance plus an R0_ZERO=1 instance
module tb_regfile_8x16;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, rd_en = 1'b0;
    logic [2:0]  waddr = '0, ra = '0, rb = '0;
    logic [15:0] wdata = '0;
    logic [15:0] a0, b0, a1, b1;
    logic        v0, v1;
    logic [65:0] obs, exp_v;
    int          pass_cnt = 0, tot_cnt = 0;

    always #5 clk = ~clk;

    regfile_8x16 u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
        .ra_addr(ra), .rb_addr(rb), .ra_data(a0), .rb_data(b0), .rd_valid(v0)
    );
    regfile_8x16 #(.R0_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
        .ra_addr(ra), .rb_addr(rb), .ra_data(a1), .rb_data(b1), .rd_valid(v1)
    );

    assign obs = {a0, b0, a1, b1, v0, v1};

    task automatic test_reset();
        #1;
        exp_v = '0;
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL reset_init: got %h exp %h", obs, exp_v); else pass_cnt++;
        @(negedge clk); rst = 0;
        we = 1; waddr = 2; wdata = 16'h1234;
        @(negedge clk); we = 0; rd_en = 1; ra = 2; rb = 2;
        @(negedge clk);
        exp_v = {16'h1234, 16'h1234, 16'h1234, 16'h1234, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL reset_preload: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0;
        #2 rst = 1;
        #1 exp_v = '0;
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL reset_async: got %h exp %h", obs, exp_v); else pass_cnt++;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; ra = 3'(i); rb = 3'(7 - i);
            @(negedge clk);
            exp_v = {64'h0, 2'b11};
            tot_cnt++;
            if (obs !== exp_v) $display("FAIL reset_read%0d: got %h exp %h", i, obs, exp_v); else pass_cnt++;
        end
        rd_en = 0;
        @(negedge clk);
        exp_v = '0;
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL reset_valid_drop: got %h exp %h", obs, exp_v); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [15:0] ea, eb;
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 16'(16'h1111 * (i + 1));
            @(negedge clk);
        end
        we = 0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; ra = 3'(i); rb = 3'(7 - i);
            @(negedge clk);
            ea = 16'(16'h1111 * (i + 1));
            eb = 16'(16'h1111 * (8 - i));
            exp_v = {ea, eb, (i == 0) ? 16'h0 : ea, (i == 7) ? 16'h0 : eb, 2'b11};
            tot_cnt++;
            if (obs !== exp_v) $display("FAIL wr_rd%0d: got %h exp %h", i, obs, exp_v); else pass_cnt++;
        end
        rd_en = 0;
    endtask

    task automatic test_bypass();
        we = 1; waddr = 3; wdata = 16'hAAAA;
        @(negedge clk);
        wdata = 16'h5555; rd_en = 1; ra = 3; rb = 3;
        @(negedge clk);
        exp_v = {16'h5555, 16'h5555, 16'h5555, 16'h5555, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL bypass: got %h exp %h", obs, exp_v); else pass_cnt++;
        we = 0;
        @(negedge clk);
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL bypass_stored: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0;
    endtask

    task automatic test_hold();
        we = 1; waddr = 1; wdata = 16'h1234;
        @(negedge clk);
        we = 0; rd_en = 1; ra = 1; rb = 1;
        @(negedge clk);
        exp_v = {16'h1234, 16'h1234, 16'h1234, 16'h1234, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL hold_read: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0; we = 1; wdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = {16'h1234, 16'h1234, 16'h1234, 16'h1234, 2'b00};
            tot_cnt++;
            if (obs !== exp_v) $display("FAIL hold%0d: got %h exp %h", i, obs, exp_v); else pass_cnt++;
        end
        we = 0; rd_en = 1;
        @(negedge clk);
        exp_v = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL hold_after: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0;
    endtask

    task automatic test_r0_zero();
        we = 1; waddr = 0; wdata = 16'hBEEF; rd_en = 1; ra = 0; rb = 0;
        @(negedge clk);
        exp_v = {16'hBEEF, 16'hBEEF, 16'h0, 16'h0, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL r0_bypass: got %h exp %h", obs, exp_v); else pass_cnt++;
        we = 0;
        @(negedge clk);
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL r0_later: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0;
    endtask

    task automatic test_async_reset();
        rd_en = 1; ra = 1; rb = 6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_v = {16'hFFFF, 16'h7777, 16'hFFFF, 16'h7777, 2'b11};
            tot_cnt++;
            if (obs !== exp_v) $display("FAIL stream%0d: got %h exp %h", i, obs, exp_v); else pass_cnt++;
        end
        #2 rst = 1;
        #1 exp_v = '0;
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL stream_rst: got %h exp %h", obs, exp_v); else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL stream_rst_held: got %h exp %h", obs, exp_v); else pass_cnt++;
        rst = 0;
        @(negedge clk);
        exp_v = {64'h0, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL stream_post: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0; we = 1; waddr = 5; wdata = 16'h0F0F;
        @(negedge clk);
        we = 0; rd_en = 1; ra = 5; rb = 5;
        @(negedge clk);
        exp_v = {16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 2'b11};
        tot_cnt++;
        if (obs !== exp_v) $display("FAIL stream_rewrite: got %h exp %h", obs, exp_v); else pass_cnt++;
        rd_en = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_hold();
        test_r0_zero();
        test_async_reset();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_8x16.md
# regfile_8x16

Eight-entry, 16-bit register file with one synchronous write port and two registered read ports (A and B). It sits directly upstream of the 16-bit 8:1 mux stage: its eight register outputs form the mux data inputs, and the read addresses drive the mux selects. Read data is captured into output registers, so downstream ALU/operand logic sees stable, registered operands. The block includes a write-first bypass and an optional hardwired-zero R0.

## Interface
- `DATA_W`, 16: register width. Fixed at 16 to match the 16-bit mux stage.
- `DEPTH`, 8: number of registers. Fixed; the address width is 3.
- `R0_ZERO`, 0: when 1, R0 always reads 0 and writes to R0 are ignored.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable.
- `waddr`  in  3  write address.
- `wdata`  in  16  write data.
- `rd_en`  in  1  read request; both ports are read in the same cycle.
- `ra_addr`  in  3  port A read address.
- `rb_addr`  in  3  port B read address.
- `ra_data`  out  16  registered port A data.
- `rb_data`  out  16  registered port B data.
- `rd_valid`  out  1  one-cycle pulse: `ra_data`/`rb_data` were updated on this edge.

## Operation
- **Storage:** eight 16-bit registers R0..R7.
- **Write:**
  - On a rising edge with `we`=1, R[`waddr`] ← `wdata`.
  - When `R0_ZERO`=1 and `waddr`=0, the write is dropped.
- **Read:**
  - Each port selects R[addr] through one 16-bit 8:1 mux; `ra_addr` or `rb_addr` drives the select bits s0..s2 (LSB first).
  - On a rising edge with `rd_en`=1, the mux outputs are captured into `ra_data` and `rb_data`.
  - When `rd_en`=0, `ra_data` and `rb_data` hold their previous values.
- **Bypass (write-first):**
  - Applies when `we`=1, `rd_en`=1 and `ra_addr`==`waddr` in the same cycle.
  - `ra_data` captures `wdata`, not the old register value.
  - Port B follows the same rule independently.
  - When `R0_ZERO`=1 and the address is 0, the bypass is suppressed and the port captures 0.
- **Same address on both ports:** A and B return identical data.
- **Handshake:**
  - There is no backpressure; every `rd_en` is serviced.
  - `rd_valid` is high for exactly the cycle after each `rd_en` cycle.
  - Back-to-back `rd_en` keeps `rd_valid` high continuously.
- **Reset:**
  - Asserting `rst` immediately clears R0..R7, `ra_data`, `rb_data` and `rd_valid` to 0, regardless of `clk`.
  - A write or read in flight during reset is lost.
  - The first edge after `rst` deasserts behaves normally.
- **Width:** no arithmetic; data passes unmodified. No X is ever driven after reset.

## Timing
- Write latency: 1 edge. Data written at edge N is readable by a read issued in cycle N+1, or by a read in cycle N via the bypass.
- Read latency: 1 edge, from `rd_en` sampled to `ra_data`/`rb_data`/`rd_valid` updated.
- Sustained throughput: one write and one dual read per cycle.
- Combinational path: `ra_addr`/`rb_addr` → 8:1 mux → bypass mux → output register D input. This path is inside one cycle; there is no combinational path from any input to any output.
- Reset values: `ra_data`=0, `rb_data`=0, `rd_valid`=0, all registers 0.

## Structure
- **Shared package:** holds the constants `RF_DATA_W`=16, `RF_DEPTH`=8, `RF_ADDR_W`=3, and the register-address type used by the decode and operand stages.
- **New sub-module `reg16_en`:** a 16-bit register with enable and async active-high reset. It is instantiated 8× for storage and 2× for the output registers.
- **Reused module:** read selection uses the existing 16-bit 8:1 mux module, one instance per port.
- **Top level:** write-address decode (3→8 one-hot AND `we`), the R0 gating, the per-port bypass compare and 2:1 select, and the `rd_valid` flop.

## Test plan
- **Reset then read:** assert `rst` mid-cycle with registers holding data; read all addresses on both ports → all `ra_data`/`rb_data` = 0x0000, `rd_valid` pulses once per `rd_en`.
- **Write and read back all registers:** write R_i = 0x1111·(i+1) for i=0..7, then read A=i, B=7−i → e.g. A=2 gives 0x3333 and B=5 gives 0x6666, both one edge after `rd_en`.
- **Bypass:** R3=0xAAAA; in one cycle `we`=1, `waddr`=3, `wdata`=0x5555, `rd_en`=1, `ra_addr`=`rb_addr`=3 → both ports = 0x5555 on the next edge, and R3 reads 0x5555 afterwards.
- **Hold:** read R1=0x1234, then drop `rd_en` for 3 cycles while writing R1=0xFFFF → outputs stay 0x1234 and `rd_valid`=0 during those cycles.
- **`R0_ZERO`=1:** write R0=0xBEEF with a simultaneous read of R0 → the read returns 0x0000 that cycle and on every later read.
- **Async reset during streaming:** assert `rst` between edges during back-to-back `rd_en` → outputs and `rd_valid` go to 0 before the next edge; after release, reads return 0 until registers are rewritten.
